// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared definitions for the byte-addressable data memory.
//   SZ_BYTE/SZ_HALF/SZ_WORD : mem_size encodings (2'b11 is reserved and behaves as a word)
//   dump_state_t            : debug dump FSM states
//   is_misaligned()         : true when an access is not naturally aligned for its size
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            default: return |lo;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// data_mem_lane_align: combinational byte-lane steering for the data memory.
//   mem_size, mem_signed : access size and load extension mode
//   addr_lo              : byte offset within the word (addr[1:0])
//   wdata                : right-aligned store data
//   rword                : current contents of the addressed word
//   byte_en              : lanes written by a store
//   wword                : store data replicated onto every lane it may land in
//   ldata                : extracted and sign/zero-extended load result
// Low offset bits are forced to the access alignment, so a half ignores
// addr_lo[0] and a word ignores both bits.
module data_mem_lane_align
    import data_mem_pkg::*;
(
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wword,
    output logic [31:0] ldata
);

    logic [1:0]  off;
    logic [31:0] shifted;

    always_comb begin
        off     = 2'b00;
        byte_en = 4'hf;
        wword   = wdata;
        shifted = rword;
        ldata   = rword;
        case (mem_size)
            SZ_BYTE: begin
                off     = addr_lo;
                byte_en = 4'b0001 << off;
                wword   = {4{wdata[7:0]}};
                shifted = rword >> {off, 3'b000};
                ldata   = {{24{shifted[7] & mem_signed}}, shifted[7:0]};
            end
            SZ_HALF: begin
                off     = {addr_lo[1], 1'b0};
                byte_en = 4'b0011 << off;
                wword   = {2{wdata[15:0]}};
                shifted = rword >> {off, 3'b000};
                ldata   = {{16{shifted[15] & mem_signed}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_lanes.sv
// data_mem_lanes: byte-addressable data memory for the MEM stage, with a debug
// dump engine that streams every word out over a valid/ready handshake.
//   clk, rst (async, active-high)
//   debug_on                 : blocks pipeline accesses, enables the dump engine
//   mem_read/mem_write       : load/store request; mem_size, mem_signed, addr, wdata
//   rdata                    : registered load result (holds when no load)
//   misalign                 : registered misalignment flag
//   dbg_start, dbg_ready     : dump start pulse / sink ready
//   dbg_valid, dbg_addr, dbg_data, dbg_done : dump stream
// Build option MISALIGN_TRAP_EN: misaligned half/word requests are suppressed
// and flagged on misalign; otherwise the low address bits are forced to the
// access alignment and misalign stays 0.
module data_mem_lanes
    import data_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        debug_on,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_size,
    input  logic        mem_signed,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        misalign,
    input  logic        dbg_start,
    output logic        dbg_valid,
    input  logic        dbg_ready,
    output logic [31:0] dbg_addr,
    output logic [31:0] dbg_data,
    output logic        dbg_done
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

    if (DATA_W != 32) begin : g_bad_width
        $error("data_mem_lanes: DATA_W must be 32");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("data_mem_lanes: DEPTH_WORDS must be a power of two >= 2");
    end

    logic [3:0][7:0] mem [DEPTH_WORDS];

    logic [AW-1:0] widx;
    logic [31:0]   rword;
    logic [3:0]    byte_en;
    logic [31:0]   wword;
    logic [31:0]   ldata;
    logic          blocked;
    logic          do_wr;
    logic          do_rd;
    logic          unused_addr_hi;

    // Upper address bits wrap: only the word index inside the array matters.
    assign widx           = addr[AW+1:2];
    assign unused_addr_hi = ^addr[31:AW+2];
    assign rword          = mem[widx];

    data_mem_lane_align u_align (
        .mem_size   (mem_size),
        .mem_signed (mem_signed),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .rword      (rword),
        .byte_en    (byte_en),
        .wword      (wword),
        .ldata      (ldata)
    );

`ifdef MISALIGN_TRAP_EN
    assign blocked = is_misaligned(mem_size, addr[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            misalign <= 1'b0;
        else if (!debug_on && (mem_read || mem_write))
            misalign <= blocked;
    end
`else
    assign blocked  = 1'b0;
    assign misalign = 1'b0;
`endif

    assign do_wr = !debug_on && mem_write && !blocked;
    assign do_rd = !debug_on && mem_read && !blocked;

    // Storage is not reset. Loads sample rword before this edge's store, so a
    // simultaneous read+write returns the old contents.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            for (int i = 0; i < 4; i++)
                if (byte_en[i]) mem[widx][i] <= wword[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (do_rd)
            rdata <= ldata;
    end

    // Dump engine
    dump_state_t   state, state_nxt;
    logic [AW-1:0] idx, idx_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            ST_IDLE: begin
                if (dbg_start && debug_on) begin
                    state_nxt = ST_SEND;
                    idx_nxt   = '0;
                end
            end
            ST_SEND: begin
                if (!debug_on)
                    state_nxt = ST_IDLE;
                else if (dbg_ready) begin
                    if (idx == LAST_IDX)
                        state_nxt = ST_DONE;
                    else
                        idx_nxt = idx + 1'b1;
                end
            end
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Stores are dropped while debug_on is high, so mem[idx] is stable while
    // a word waits for dbg_ready.
    assign dbg_valid = (state == ST_SEND);
    assign dbg_done  = (state == ST_DONE);
    assign dbg_addr  = dbg_valid ? {{(32-AW){1'b0}}, idx} : '0;
    assign dbg_data  = dbg_valid ? mem[idx] : '0;

endmodule

// File: tb/tb_data_mem_lanes.sv
module tb_data_mem_lanes;

    localparam int DW = 32;
    localparam int NB = DW * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        debug_on, mem_read, mem_write, mem_signed;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        misalign;
    logic        dbg_start, dbg_valid, dbg_ready, dbg_done;
    logic [31:0] dbg_addr, dbg_data;

    always #5 clk = ~clk;

    data_mem_lanes #(.DEPTH_WORDS(DW), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .debug_on(debug_on),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_signed(mem_signed), .addr(addr), .wdata(wdata),
        .rdata(rdata), .misalign(misalign),
        .dbg_start(dbg_start), .dbg_valid(dbg_valid), .dbg_ready(dbg_ready),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_done(dbg_done)
    );

    // Reference model: flat byte array, little-endian lanes.
    logic [7:0]  mref [NB];
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          n_vec, n_err;

    function automatic int eff_addr(input logic [1:0] sz, input logic [31:0] a);
        int b;
        b = int'(a % NB);
`ifndef MISALIGN_TRAP_EN
        if (sz == 2'd1)      b = b - (b % 2);
        else if (sz >= 2'd2) b = b - (b % 4);
`endif
        return b;
    endfunction

    function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return (a % 2) != 0;
        if (sz >= 2'd2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {mref[4*w+3], mref[4*w+2], mref[4*w+1], mref[4*w]};
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input int b);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = {24'h0, mref[b]};
            if (sg && mref[b][7]) v[31:8] = '1;
        end else if (sz == 2'd1) begin
            v = {16'h0, mref[b+1], mref[b]};
            if (sg && mref[b+1][7]) v[31:16] = '1;
        end else begin
            v = {mref[b+3], mref[b+2], mref[b+1], mref[b]};
        end
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int b, input logic [31:0] wd);
        int nb;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int k = 0; k < nb; k++) mref[b+k] = wd[8*k +: 8];
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Applies one request for a cycle and advances the model; checks are done by callers.
    task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic dbg);
        int   b;
        logic blk;
        debug_on = dbg; mem_read = rd; mem_write = wr; mem_size = sz;
        mem_signed = sg; addr = a; wdata = wd;
        b   = eff_addr(sz, a);
        blk = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (!dbg && (rd || wr)) begin
            exp_mis = misal(sz, a);
            blk     = exp_mis;
        end
`endif
        if (!dbg && rd && !blk) exp_rdata = ref_load(sz, sg, b);
        if (!dbg && wr && !blk) ref_store(sz, b, wd);
        tick();
        mem_read = 1'b0; mem_write = 1'b0; debug_on = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        debug_on = 0; mem_read = 0; mem_write = 0; mem_size = 0; mem_signed = 0;
        addr = 0; wdata = 0; dbg_start = 0; dbg_ready = 0;
        exp_rdata = '0; exp_mis = 1'b0;
        tick(); tick();
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL reset_misalign: got %b want 0", misalign); end
        n_vec++; if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL reset_dbg_valid: got %b want 0", dbg_valid); end
        n_vec++; if (dbg_addr !== 32'h0) begin n_err++; $display("FAIL reset_dbg_addr: got %h want 0", dbg_addr); end
        n_vec++; if (dbg_data !== 32'h0) begin n_err++; $display("FAIL reset_dbg_data: got %h want 0", dbg_data); end
        n_vec++; if (dbg_done !== 1'b0) begin n_err++; $display("FAIL reset_dbg_done: got %b want 0", dbg_done); end
        rst = 1'b0;
        tick();
    endtask

    task automatic prefill();
        for (int w = 0; w < DW; w++) op(1'b0, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0);
    endtask

    task automatic test_directed();
        op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0);
        op(1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        n_vec++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL sw_lw: got %h want deadbeef", rdata); end
        op(0, 1, 2'd2, 0, 32'h10, 32'h0, 0);
        op(0, 1, 2'd0, 0, 32'h13, 32'h80, 0);
        op(1, 0, 2'd0, 1, 32'h13, 32'h0, 0);
        n_vec++; if (rdata !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb_signed: got %h want ffffff80", rdata); end
        op(1, 0, 2'd0, 0, 32'h13, 32'h0, 0);
        n_vec++; if (rdata !== 32'h00000080) begin n_err++; $display("FAIL lbu: got %h want 00000080", rdata); end
        op(1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        n_vec++; if (rdata !== 32'h80000000) begin n_err++; $display("FAIL sb_lane3: got %h want 80000000", rdata); end
        op(0, 1, 2'd2, 0, 32'h20, 32'hAAAAAAAA, 0);
        op(0, 1, 2'd1, 0, 32'h22, 32'h00001234, 0);
        op(1, 0, 2'd2, 0, 32'h20, 32'h0, 0);
        n_vec++; if (rdata !== 32'h1234AAAA) begin n_err++; $display("FAIL sh_upper: got %h want 1234aaaa", rdata); end
        op(1, 1, 2'd2, 0, 32'h20, 32'h55555555, 0);
        n_vec++; if (rdata !== 32'h1234AAAA) begin n_err++; $display("FAIL rw_old_data: got %h want 1234aaaa", rdata); end
        op(1, 0, 2'd2, 0, 32'h20, 32'h0, 0);
        n_vec++; if (rdata !== 32'h55555555) begin n_err++; $display("FAIL rw_new_data: got %h want 55555555", rdata); end
        tick(); tick();
        n_vec++; if (rdata !== 32'h55555555) begin n_err++; $display("FAIL rdata_hold: got %h want 55555555", rdata); end
        op(0, 1, 2'd2, 0, 32'h40, 32'h0, 0);
        op(0, 1, 2'd2, 0, 32'h41, 32'h11111111, 0);
`ifdef MISALIGN_TRAP_EN
        n_vec++; if (misalign !== 1'b1) begin n_err++; $display("FAIL misalign_set: got %b want 1", misalign); end
        op(1, 0, 2'd2, 0, 32'h40, 32'h0, 0);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL misalign_store_dropped: got %h want 0", rdata); end
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL misalign_clear: got %b want 0", misalign); end
`else
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL misalign_tied: got %b want 0", misalign); end
        op(1, 0, 2'd2, 0, 32'h40, 32'h0, 0);
        n_vec++; if (rdata !== 32'h11111111) begin n_err++; $display("FAIL forced_align: got %h want 11111111", rdata); end
`endif
        op(0, 1, 2'd2, 0, 32'h90, 32'hCAFEF00D, 0);
        op(1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        n_vec++; if (rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL addr_wrap: got %h want cafef00d", rdata); end
    endtask

    task automatic test_debug_block();
        op(0, 1, 2'd2, 0, 32'h10, 32'h12345678, 1);
        op(1, 0, 2'd2, 0, 32'h20, 32'h0, 1);
        n_vec++; if (rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL dbg_rdata_hold: got %h want cafef00d", rdata); end
        op(1, 0, 2'd2, 0, 32'h10, 32'h0, 0);
        n_vec++; if (rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL dbg_store_dropped: got %h want cafef00d", rdata); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 9) == 0));
            n_vec++; if (rdata !== exp_rdata) begin n_err++; $display("FAIL rand_rdata[%0d]: got %h want %h", i, rdata, exp_rdata); end
            n_vec++; if (misalign !== exp_mis) begin n_err++; $display("FAIL rand_misalign[%0d]: got %b want %b", i, misalign, exp_mis); end
        end
    endtask

    task automatic test_dump();
        int   n, dones;
        logic tog;
        n = 0; dones = 0; tog = 1'b0;
        debug_on = 1'b1; dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0;
        for (int cyc = 0; cyc < 300 && n < DW; cyc++) begin
            if (dbg_done) dones++;
            n_vec++; if (dbg_valid !== 1'b1) begin n_err++; $display("FAIL dump_valid[%0d]: got %b want 1", n, dbg_valid); end
            n_vec++; if (dbg_addr !== 32'(n)) begin n_err++; $display("FAIL dump_addr: got %0d want %0d", dbg_addr, n); end
            n_vec++; if (dbg_data !== ref_word(n)) begin n_err++; $display("FAIL dump_data[%0d]: got %h want %h", n, dbg_data, ref_word(n)); end
            dbg_ready = tog;
            tog       = ~tog;
            dbg_start = (n == 5);
            if (dbg_ready) n++;
            tick();
        end
        dbg_ready = 1'b0; dbg_start = 1'b0;
        n_vec++; if (n != DW) begin n_err++; $display("FAIL dump_timeout: got %0d words want %0d", n, DW); end
        for (int k = 0; k < 3; k++) begin
            if (dbg_done) dones++;
            n_vec++; if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL dump_end_valid: got %b want 0", dbg_valid); end
            tick();
        end
        n_vec++; if (dones != 1) begin n_err++; $display("FAIL dump_done_count: got %0d want 1", dones); end
        debug_on = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        debug_on = 1'b1; dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0; dbg_ready = 1'b1;
        tick(); tick(); tick();
        n_vec++; if (dbg_addr !== 32'd3) begin n_err++; $display("FAIL abort_pre_addr: got %0d want 3", dbg_addr); end
        debug_on = 1'b0; dbg_ready = 1'b0;
        tick();
        n_vec++; if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL abort_valid: got %b want 0", dbg_valid); end
        for (int k = 0; k < 3; k++) begin
            n_vec++; if (dbg_done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", dbg_done); end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        debug_on = 1'b1; dbg_start = 1'b1;
        tick();
        dbg_start = 1'b0; dbg_ready = 1'b1;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        n_vec++; if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", dbg_valid); end
        n_vec++; if (dbg_addr !== 32'h0) begin n_err++; $display("FAIL rstmid_addr: got %h want 0", dbg_addr); end
        n_vec++; if (dbg_data !== 32'h0) begin n_err++; $display("FAIL rstmid_data: got %h want 0", dbg_data); end
        n_vec++; if (dbg_done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b want 0", dbg_done); end
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rstmid_rdata: got %h want 0", rdata); end
        n_vec++; if (misalign !== 1'b0) begin n_err++; $display("FAIL rstmid_misalign: got %b want 0", misalign); end
        @(negedge clk);
        rst = 1'b0;
        tick(); tick();
        n_vec++; if (dbg_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b want 0", dbg_valid); end
        dbg_start = 1'b1; dbg_ready = 1'b0;
        tick();
        dbg_start = 1'b0;
        n_vec++; if (dbg_valid !== 1'b1 || dbg_addr !== 32'h0) begin
            n_err++; $display("FAIL rstmid_restart: got valid=%b addr=%0d want valid=1 addr=0", dbg_valid, dbg_addr);
        end
        debug_on = 1'b0;
        tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        test_reset();
        prefill();
        test_directed();
        test_debug_block();
        test_random();
        test_dump();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
